// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
// Frame constants and baud divider derivation are common with the transmitter.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BAUD_CNT_W = 16;
  localparam int unsigned BIT_CNT_W  = 3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clock cycles per bit; integer division truncates like the transmitter does.
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Reset value is a parameter so an idle-high serial line resets to 1.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a synchronised line, one-cycle
// valid strobe per good byte, one-cycle frame error pulse per bad stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(HALF_DIV - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

  generate
    if (BAUD_DIV < 4 || BAUD_DIV > 65535) begin : g_bad_baud
      $error("uart_rx: BAUD_DIV out of range 4..65535");
    end
  endgenerate

  logic rx_sync;

  rx_state_e              state, state_nxt;
  logic [BAUD_CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0]   shift_reg, shift_nxt;
  logic [DATA_BITS-1:0]   data_nxt;
  logic                   valid_nxt;
  logic                   busy_nxt;
  logic                   ferr_nxt;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_serial),
    .q  (rx_sync)
  );

  // State and datapath registers; reset overrides any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      rx_busy   <= busy_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    data_nxt     = rx_data;
    valid_nxt    = 1'b0;
    ferr_nxt     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rx_sync == START_BIT) begin
          state_nxt    = ST_START;
          baud_cnt_nxt = '0;
        end
      end

      // Half a bit after the edge: confirm the start bit or reject a glitch.
      ST_START: begin
        if (baud_cnt == HALF_LAST) begin
          if (rx_sync == START_BIT) begin
            state_nxt    = ST_DATA;
            baud_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          shift_nxt    = {rx_sync, shift_reg[DATA_BITS-1:1]};
          bit_cnt_nxt  = bit_cnt + BIT_CNT_W'(1);
          baud_cnt_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = ST_STOP;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_nxt = '0;
          if (rx_sync == STOP_BIT) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_WAIT_HIGH;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + BAUD_CNT_W'(1);
        end
      end

      // A held-low line reports once, then waits for idle before rearming.
      ST_WAIT_HIGH: begin
        if (rx_sync == STOP_BIT) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
